keypad_scanner: RTL and testbench

- Column-scanning FSM for the 4x4 matrix keypad.
- Drives the keypad columns and samples the row inputs through a synchronizer.
- Sits directly upstream of the debouncer: asserts debouncer_counter_en and consumes debounce_done to qualify presses and releases.
- Emits one key_valid pulse plus a hex key_code per confirmed press; downstream display/shift logic consumes these.

---
 rtl/keypad_scanner.sv | 203 ++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - column-scanning FSM for a 4x4 matrix keypad with debouncer handshake

module keypad_scanner #(
    parameter int SCAN_DIV    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    input  logic       debounce_done,
    output logic [3:0] cols,
    output logic       debouncer_counter_en,
    output logic       key_valid,
    output logic [3:0] key_code
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [2:0] ST_SCAN     = 3'd0;
    localparam logic [2:0] ST_DEBOUNCE = 3'd1;
    localparam logic [2:0] ST_CONFIRM  = 3'd2;
    localparam logic [2:0] ST_HELD     = 3'd3;
    localparam logic [2:0] ST_REL_DB   = 3'd4;

    logic [3:0]       sync_q [SYNC_STAGES];
    logic [3:0]       rows_s;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [3:0]       cols_nxt;
    logic [3:0]       cols_rot;
    logic [1:0]       row_idx;
    logic [1:0]       row_idx_nxt;
    logic [1:0]       col_idx;
    logic [1:0]       col_idx_nxt;
    logic             key_valid_nxt;
    logic [3:0]       key_code_nxt;

    logic [1:0]       hit_row;
    logic [1:0]       cur_col;
    logic             row_hit;
    logic             dwell_done;

    // Row code for each (row, column) position of the keypad legend
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    // Row synchronizer: raw pins are asynchronous to clk
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= rows;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign rows_s     = sync_q[SYNC_STAGES-1];
    assign cols_rot   = {cols[2:0], cols[3]};
    assign row_hit    = rows_s[row_idx];
    assign dwell_done = (cnt == CNT_W'(SCAN_DIV - 1));

    // Lowest-index active row wins when several keys share the column
    always_comb begin
        hit_row = 2'd3;
        if (rows_s[0]) begin
            hit_row = 2'd0;
        end else if (rows_s[1]) begin
            hit_row = 2'd1;
        end else if (rows_s[2]) begin
            hit_row = 2'd2;
        end
    end

    // Index of the column currently being driven
    always_comb begin
        case (cols)
            4'b0010: cur_col = 2'd1;
            4'b0100: cur_col = 2'd2;
            4'b1000: cur_col = 2'd3;
            default: cur_col = 2'd0;
        endcase
    end

    // Scan / debounce / hold sequencing
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        cols_nxt      = cols;
        row_idx_nxt   = row_idx;
        col_idx_nxt   = col_idx;
        key_valid_nxt = 1'b0;
        key_code_nxt  = key_code;
        case (state)
            ST_SCAN: begin
                if (dwell_done) begin
                    cnt_nxt = '0;
                    if (rows_s == 4'b0000) begin
                        cols_nxt = cols_rot;
                    end else begin
                        row_idx_nxt = hit_row;
                        col_idx_nxt = cur_col;
                        state_nxt   = ST_DEBOUNCE;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_DEBOUNCE: begin
                // The press decision is taken on the done edge so the pulse and
                // its code appear together in the CONFIRM cycle.
                if (debounce_done) begin
                    state_nxt = ST_CONFIRM;
                    if (row_hit) begin
                        key_valid_nxt = 1'b1;
                        key_code_nxt  = key_map(row_idx, col_idx);
                    end
                end
            end
            ST_CONFIRM: begin
                // Follow the decision already made so a pulse always leads to HELD
                if (key_valid) begin
                    state_nxt = ST_HELD;
                end else begin
                    cols_nxt  = cols_rot;
                    cnt_nxt   = '0;
                    state_nxt = ST_SCAN;
                end
            end
            ST_HELD: begin
                if (!row_hit) begin
                    state_nxt = ST_REL_DB;
                end
            end
            ST_REL_DB: begin
                if (debounce_done) begin
                    if (!row_hit) begin
                        cols_nxt  = cols_rot;
                        cnt_nxt   = '0;
                        state_nxt = ST_SCAN;
                    end else begin
                        state_nxt = ST_HELD;
                    end
                end
            end
            default: begin
                cols_nxt  = 4'b0001;
                cnt_nxt   = '0;
                state_nxt = ST_SCAN;
            end
        endcase
    end

    // FSM, column drive, latched key position and key outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_SCAN;
            cnt       <= '0;
            cols      <= 4'b0001;
            row_idx   <= 2'd0;
            col_idx   <= 2'd0;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cols      <= cols_nxt;
            row_idx   <= row_idx_nxt;
            col_idx   <= col_idx_nxt;
            key_valid <= key_valid_nxt;
            key_code  <= key_code_nxt;
        end
    end

    assign debouncer_counter_en = (state == ST_DEBOUNCE) || (state == ST_REL_DB);

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner

module tb_keypad_scanner;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      rows;
    logic            debounce_done;
    logic [3:0]      cols;
    logic            en;
    logic            key_valid;
    logic [3:0]      key_code;

    logic [3:0][3:0] pressed;
    logic            done_force;
    logic [1:0]      dcnt;

    int errors = 0;
    int checks = 0;
    int pulses;

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(4), .SYNC_STAGES(2)) dut (
        .clk                  (clk),
        .reset                (reset),
        .rows                 (rows),
        .debounce_done        (debounce_done),
        .cols                 (cols),
        .debouncer_counter_en (en),
        .key_valid            (key_valid),
        .key_code             (key_code)
    );

    // Keypad matrix: a pressed key connects its column drive to its row
    always_comb begin
        rows = 4'b0000;
        for (int r = 0; r < 4; r++) begin
            rows[r] = |(pressed[r] & cols);
        end
    end

    // Debouncer: done rises 3 cycles after enable rises, clears when enable drops
    always @(posedge clk) begin
        if (!reset || !en) dcnt <= 2'd0;
        else if (dcnt != 2'd3) dcnt <= dcnt + 2'd1;
    end
    assign debounce_done = done_force | (dcnt == 2'd3);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_en(input logic lvl, input string tag);
        int n = 0;
        while (en !== lvl && n < 200) begin
            tick;
            n++;
        end
        chk(tag, {31'd0, en}, {31'd0, lvl});
    endtask

    task automatic press_key(input int r, input int c, input logic [3:0] exp);
        int n = 0;
        pressed = '0;
        pressed[r][c] = 1'b1;
        while (key_valid !== 1'b1 && n < 200) begin
            tick;
            n++;
        end
        chk($sformatf("key r%0d c%0d pulse", r, c), {31'd0, key_valid}, 32'd1);
        chk($sformatf("key r%0d c%0d code", r, c), {28'd0, key_code}, {28'd0, exp});
        tick;
        chk($sformatf("key r%0d c%0d single pulse", r, c), {31'd0, key_valid}, 32'd0);
        pressed = '0;
        wait_en(1'b1, $sformatf("key r%0d c%0d release en", r, c));
        wait_en(1'b0, $sformatf("key r%0d c%0d release done", r, c));
    endtask

    initial begin
        reset      = 1'b0;
        pressed    = '0;
        done_force = 1'b0;
        tick;
        tick;
        chk("reset cols", {28'd0, cols}, 32'h1);
        chk("reset en", {31'd0, en}, 32'd0);
        chk("reset key_valid", {31'd0, key_valid}, 32'd0);
        chk("reset key_code", {28'd0, key_code}, 32'h0);

        // Idle rotation, with a stray done pulse while scanning
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 8) done_force = 1'b1;
            if (i == 14) done_force = 1'b0;
            chk($sformatf("idle cols %0d", i), {28'd0, cols}, 32'd1 << ((i / 4) % 4));
            chk($sformatf("idle en %0d", i), {31'd0, en}, 32'd0);
            chk($sformatf("idle kv %0d", i), {31'd0, key_valid}, 32'd0);
            if (i < 19) tick;
        end

        // Single press of '5' (row 1, column 1)
        pressed[1][1] = 1'b1;
        repeat (4) tick;
        chk("p5 en before", {31'd0, en}, 32'd0);
        tick;
        chk("p5 en rise", {31'd0, en}, 32'd1);
        chk("p5 cols frozen", {28'd0, cols}, 32'h2);
        repeat (3) tick;
        chk("p5 en still", {31'd0, en}, 32'd1);
        chk("p5 no early kv", {31'd0, key_valid}, 32'd0);
        chk("p5 cols db", {28'd0, cols}, 32'h2);
        tick;
        chk("p5 kv", {31'd0, key_valid}, 32'd1);
        chk("p5 code", {28'd0, key_code}, 32'h5);
        chk("p5 en confirm", {31'd0, en}, 32'd0);
        tick;
        chk("p5 kv drop", {31'd0, key_valid}, 32'd0);
        chk("p5 code hold", {28'd0, key_code}, 32'h5);

        // Hold for 100 cycles: no repeated pulse
        pulses = 0;
        repeat (99) begin
            tick;
            if (key_valid === 1'b1) pulses++;
        end
        chk("hold pulses", pulses, 32'd0);
        chk("hold cols", {28'd0, cols}, 32'h2);
        chk("hold en", {31'd0, en}, 32'd0);

        // Release with bounce at done time
        pressed = '0;
        repeat (2) tick;
        chk("rel en low", {31'd0, en}, 32'd0);
        tick;
        chk("rel en rise", {31'd0, en}, 32'd1);
        pressed[1][1] = 1'b1;
        repeat (3) tick;
        chk("relb en", {31'd0, en}, 32'd1);
        tick;
        chk("relb back held en", {31'd0, en}, 32'd0);
        chk("relb no kv", {31'd0, key_valid}, 32'd0);
        chk("relb cols", {28'd0, cols}, 32'h2);
        chk("relb code", {28'd0, key_code}, 32'h5);

        // Clean release
        pressed = '0;
        repeat (2) tick;
        chk("crel en low", {31'd0, en}, 32'd0);
        tick;
        chk("crel en rise", {31'd0, en}, 32'd1);
        repeat (3) tick;
        chk("crel cols frozen", {28'd0, cols}, 32'h2);
        chk("crel en still", {31'd0, en}, 32'd1);
        tick;
        chk("crel cols resume", {28'd0, cols}, 32'h4);
        chk("crel en off", {31'd0, en}, 32'd0);
        chk("crel kv", {31'd0, key_valid}, 32'd0);

        // Press bounce: row drops before done
        repeat (8) tick;
        chk("pb cols c0", {28'd0, cols}, 32'h1);
        pressed[1][1] = 1'b1;
        repeat (8) tick;
        chk("pb en", {31'd0, en}, 32'd1);
        chk("pb cols", {28'd0, cols}, 32'h2);
        pressed = '0;
        repeat (4) tick;
        chk("pb no kv", {31'd0, key_valid}, 32'd0);
        chk("pb en confirm", {31'd0, en}, 32'd0);
        chk("pb code kept", {28'd0, key_code}, 32'h5);
        tick;
        chk("pb cols resume", {28'd0, cols}, 32'h4);
        chk("pb en scan", {31'd0, en}, 32'd0);

        // Same-column conflict on column 3: row 0 beats row 2
        pressed[0][3] = 1'b1;
        pressed[2][3] = 1'b1;
        repeat (4) tick;
        chk("cf cols c3", {28'd0, cols}, 32'h8);
        repeat (4) tick;
        chk("cf en", {31'd0, en}, 32'd1);
        repeat (4) tick;
        chk("cf kv", {31'd0, key_valid}, 32'd1);
        chk("cf code", {28'd0, key_code}, 32'hA);
        tick;
        chk("cf kv drop", {31'd0, key_valid}, 32'd0);
        pressed = '0;
        wait_en(1'b1, "cf release en");
        wait_en(1'b0, "cf release done");

        // Key map spot checks
        press_key(3, 1, 4'h0);
        press_key(3, 0, 4'hE);
        press_key(2, 2, 4'h9);
        press_key(0, 0, 4'h1);
        press_key(3, 3, 4'hD);
        press_key(1, 3, 4'hB);

        // Reset in the middle of a press debounce
        pressed[2][0] = 1'b1;
        wait_en(1'b1, "mr en before reset");
        reset = 1'b0;
        #1;
        chk("mr en", {31'd0, en}, 32'd0);
        chk("mr cols", {28'd0, cols}, 32'h1);
        chk("mr code", {28'd0, key_code}, 32'h0);
        chk("mr kv", {31'd0, key_valid}, 32'd0);
        pressed = '0;
        tick;
        tick;
        reset = 1'b1;
        chk("mr restart c0", {28'd0, cols}, 32'h1);
        repeat (3) tick;
        chk("mr dwell c0", {28'd0, cols}, 32'h1);
        tick;
        chk("mr next c1", {28'd0, cols}, 32'h2);
        chk("mr en idle", {31'd0, en}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
